alarm_bell_n: RTL and testbench

Parametrised multi-channel alarm and hourly-chime controller for the BCD digital clock. It compares the running BCD time against N independently enabled alarm settings. It rings with a 1 s on/off beat for a bounded duration and supports snooze with a bounded repeat count. When no alarm is active, it emits the classic four-low/one-high hourly chime. It sits beside the hour/minute/second counters and drives the buzzer pin directly.

---
 rtl/alarm_bell_n.sv | 204 ++++++++++++++++++++
 tb/tb_alarm_bell_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bell_n.sv
// alarm_bell_n
// Multi-channel alarm and hourly-chime controller for the BCD digital clock.
// It compares the running BCD time against N_ALARM enabled alarm settings.
// While ringing, the bell sounds on a 1 s on/off beat for RING_SEC seconds.
// Snooze pauses the bell for SNOOZE_MIN minutes, up to MAX_SNOOZE times per
// alarm event. When no alarm is active, the bell gives the four-low/one-high
// hourly chime.
//
// Ports
//   CP          system clock, rising edge
//   CR          synchronous active-high reset
//   Tick1Hz     one-cycle strobe per second, aligned with the time update
//   ToneHi/Lo   square-wave tone sources
//   Hour/Min/Sec current time, BCD
//   AlmHr/AlmMin alarm settings, BCD, channel i at [8i+7:8i]
//   AlmEn       per-channel alarm enable
//   SnoozeKey   debounced key level (rising edge acts)
//   StopKey     debounced key level (rising edge acts)
//   Bell        buzzer drive
//   Ringing     high while in RING
//   Snoozing    high while in SNOOZE
//   ActCh       channel that owns the current alarm event
//
// Handshake: none. The keys are levels, Tick1Hz is a single-cycle strobe, and
// every output is a plain level.
module alarm_bell_n #(
   parameter int N_ALARM    = 4,
   parameter int CH_W       = 2,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3,
   parameter int CHIME      = 1
) (
   input  logic                 CP,
   input  logic                 CR,
   input  logic                 Tick1Hz,
   input  logic                 ToneHi,
   input  logic                 ToneLo,
   input  logic [7:0]           Hour,
   input  logic [7:0]           Min,
   input  logic [7:0]           Sec,
   input  logic [N_ALARM*8-1:0] AlmHr,
   input  logic [N_ALARM*8-1:0] AlmMin,
   input  logic [N_ALARM-1:0]   AlmEn,
   input  logic                 SnoozeKey,
   input  logic                 StopKey,
   output logic                 Bell,
   output logic                 Ringing,
   output logic                 Snoozing,
   output logic [CH_W-1:0]      ActCh
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
   localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_MIN * 60 - 1);
   localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

   state_t            state_q, state_d;
   logic [CH_W-1:0]   act_ch_q, act_ch_d;
   logic              beat_q, beat_d;
   logic [7:0]        ring_cnt_q, ring_cnt_d;
   logic [9:0]        snz_cnt_q, snz_cnt_d;
   logic [2:0]        snz_used_q, snz_used_d;

   // Two-stage key sampling. The edge comes from the registered pair, so the
   // state moves on the second edge after the key rises.
   logic snz_key_q, snz_key_prev_q;
   logic stop_key_q, stop_key_prev_q;
   logic snz_edge, stop_edge;

   logic            match_any;
   logic [CH_W-1:0] match_ch;
   logic            act_en;

   assign snz_edge  = snz_key_q & ~snz_key_prev_q;
   assign stop_edge = stop_key_q & ~stop_key_prev_q;

   // Lowest matching channel wins. The loop scans downward so the last hit
   // assigned is the lowest index.
   always_comb begin
      match_any = 1'b0;
      match_ch  = '0;
      for (int i = N_ALARM - 1; i >= 0; i--) begin
         if (AlmEn[i] && Hour == AlmHr[8*i +: 8] && Min == AlmMin[8*i +: 8]
             && Sec == 8'h00) begin
            match_any = 1'b1;
            match_ch  = CH_W'(i);
         end
      end
   end

   // Enable of the owning channel. A loop avoids indexing past N_ALARM.
   always_comb begin
      act_en = 1'b0;
      for (int i = 0; i < N_ALARM; i++) begin
         if (act_ch_q == CH_W'(i)) act_en = AlmEn[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      act_ch_d   = act_ch_q;
      beat_d     = beat_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      snz_used_d = snz_used_q;
      case (state_q)
         ST_IDLE: begin
            if (Tick1Hz && match_any) begin
               state_d    = ST_RING;
               act_ch_d   = match_ch;
               ring_cnt_d = '0;
               beat_d     = 1'b1;
               snz_used_d = '0;
            end
         end
         ST_RING: begin
            // A key transition takes precedence over a same-cycle tick.
            if (stop_edge || !act_en) begin
               state_d = ST_IDLE;
            end else if (snz_edge && snz_used_q < SNZ_MAX) begin
               state_d    = ST_SNOOZE;
               snz_cnt_d  = '0;
               snz_used_d = snz_used_q + 3'd1;
            end else if (Tick1Hz) begin
               if (ring_cnt_q == RING_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  ring_cnt_d = ring_cnt_q + 8'd1;
                  beat_d     = ~beat_q;
               end
            end
         end
         ST_SNOOZE: begin
            if (stop_edge || !act_en) begin
               state_d = ST_IDLE;
            end else if (Tick1Hz) begin
               if (snz_cnt_q == SNZ_LAST) begin
                  state_d    = ST_RING;
                  ring_cnt_d = '0;
                  beat_d     = 1'b1;
               end else begin
                  snz_cnt_d = snz_cnt_q + 10'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CP) begin
      if (CR) begin
         state_q         <= ST_IDLE;
         act_ch_q        <= '0;
         beat_q          <= 1'b0;
         ring_cnt_q      <= '0;
         snz_cnt_q       <= '0;
         snz_used_q      <= '0;
         // Load the live key level so a key held through reset gives no edge.
         snz_key_q       <= SnoozeKey;
         snz_key_prev_q  <= SnoozeKey;
         stop_key_q      <= StopKey;
         stop_key_prev_q <= StopKey;
      end else begin
         state_q         <= state_d;
         act_ch_q        <= act_ch_d;
         beat_q          <= beat_d;
         ring_cnt_q      <= ring_cnt_d;
         snz_cnt_q       <= snz_cnt_d;
         snz_used_q      <= snz_used_d;
         snz_key_q       <= SnoozeKey;
         snz_key_prev_q  <= snz_key_q;
         stop_key_q      <= StopKey;
         stop_key_prev_q <= stop_key_q;
      end
   end

   // Bell is combinational so the tone passes through without a cycle of lag.
   always_comb begin
      Bell = 1'b0;
      case (state_q)
         ST_RING: Bell = ToneHi & beat_q;
         ST_IDLE: begin
            if (CHIME != 0 && Min == 8'h59) begin
               if (Sec == 8'h51 || Sec == 8'h53 || Sec == 8'h55 || Sec == 8'h57)
                  Bell = ToneLo;
               else if (Sec == 8'h59)
                  Bell = ToneHi;
            end
         end
         default: Bell = 1'b0;
      endcase
   end

   assign Ringing  = (state_q == ST_RING);
   assign Snoozing = (state_q == ST_SNOOZE);
   assign ActCh    = act_ch_q;

endmodule

// File: tb/tb_alarm_bell_n.sv
// Directed bench for alarm_bell_n with RING_SEC=4, SNOOZE_MIN=1 and
// MAX_SNOOZE=1. A second instance with CHIME=0 shares every input.
module tb_alarm_bell_n;

   localparam int N = 4;

   logic         CP = 1'b0;
   logic         CR = 1'b1;
   logic         Tick1Hz = 1'b0;
   logic         ToneHi = 1'b0;
   logic         ToneLo = 1'b0;
   logic [7:0]   Hour = 8'h00;
   logic [7:0]   Min = 8'h00;
   logic [7:0]   Sec = 8'h00;
   logic [N*8-1:0] AlmHr = '0;
   logic [N*8-1:0] AlmMin = '0;
   logic [N-1:0] AlmEn = '0;
   logic         SnoozeKey = 1'b0;
   logic         StopKey = 1'b0;

   logic         bell, ringing, snoozing;
   logic [1:0]   act_ch;
   logic         bell_nc, ringing_nc, snoozing_nc;
   logic [1:0]   act_ch_nc;

   int checks = 0;
   int errors = 0;
   int tod    = 0;

   alarm_bell_n #(.N_ALARM(4), .CH_W(2), .RING_SEC(4), .SNOOZE_MIN(1),
                  .MAX_SNOOZE(1), .CHIME(1)) dut (
      .CP(CP), .CR(CR), .Tick1Hz(Tick1Hz), .ToneHi(ToneHi), .ToneLo(ToneLo),
      .Hour(Hour), .Min(Min), .Sec(Sec), .AlmHr(AlmHr), .AlmMin(AlmMin),
      .AlmEn(AlmEn), .SnoozeKey(SnoozeKey), .StopKey(StopKey),
      .Bell(bell), .Ringing(ringing), .Snoozing(snoozing), .ActCh(act_ch)
   );

   alarm_bell_n #(.N_ALARM(4), .CH_W(2), .RING_SEC(4), .SNOOZE_MIN(1),
                  .MAX_SNOOZE(1), .CHIME(0)) dut_nc (
      .CP(CP), .CR(CR), .Tick1Hz(Tick1Hz), .ToneHi(ToneHi), .ToneLo(ToneLo),
      .Hour(Hour), .Min(Min), .Sec(Sec), .AlmHr(AlmHr), .AlmMin(AlmMin),
      .AlmEn(AlmEn), .SnoozeKey(SnoozeKey), .StopKey(StopKey),
      .Bell(bell_nc), .Ringing(ringing_nc), .Snoozing(snoozing_nc),
      .ActCh(act_ch_nc)
   );

   // clock
   always #5 CP = ~CP;

   typedef struct {
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
      logic       hi;
      logic       lo;
      logic       exp_bell;
   } chime_vec_t;

   chime_vec_t vecs[22];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic set_tod(input int t);
      tod  = t;
      Hour = bcd(t / 3600);
      Min  = bcd((t / 60) % 60);
      Sec  = bcd(t % 60);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CP);
         #1;
      end
   endtask

   // Advance the time by one second with the tick in the same cycle, then
   // one quiet cycle.
   task automatic advance();
      set_tod(tod + 1);
      Tick1Hz = 1'b1;
      cycles(1);
      Tick1Hz = 1'b0;
      cycles(1);
   endtask

   task automatic key_pulse(input logic snz, input logic stp);
      SnoozeKey = snz;
      StopKey   = stp;
      cycles(2);
      SnoozeKey = 1'b0;
      StopKey   = 1'b0;
      cycles(2);
   endtask

   function automatic int hms(input int h, input int m, input int s);
      return h * 3600 + m * 60 + s;
   endfunction

   task automatic ring_ch1();
      set_tod(hms(7, 29, 59));
      cycles(1);
      advance();
   endtask

   initial begin
      // 09:59:50 .. 10:00:00, probing each second with each tone alone.
      vecs[0]  = '{8'h09, 8'h59, 8'h50, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{8'h09, 8'h59, 8'h50, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{8'h09, 8'h59, 8'h51, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{8'h09, 8'h59, 8'h51, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{8'h09, 8'h59, 8'h52, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{8'h09, 8'h59, 8'h52, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{8'h09, 8'h59, 8'h53, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{8'h09, 8'h59, 8'h53, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{8'h09, 8'h59, 8'h54, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{8'h09, 8'h59, 8'h54, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{8'h09, 8'h59, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{8'h09, 8'h59, 8'h55, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{8'h09, 8'h59, 8'h56, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{8'h09, 8'h59, 8'h56, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{8'h09, 8'h59, 8'h57, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{8'h09, 8'h59, 8'h57, 1'b0, 1'b1, 1'b1};
      vecs[16] = '{8'h09, 8'h59, 8'h58, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{8'h09, 8'h59, 8'h58, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{8'h09, 8'h59, 8'h59, 1'b1, 1'b0, 1'b1};
      vecs[19] = '{8'h09, 8'h59, 8'h59, 1'b0, 1'b1, 1'b0};
      vecs[20] = '{8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

      // reset
      ToneHi = 1'b1;
      ToneLo = 1'b1;
      set_tod(hms(1, 2, 3));
      cycles(2);
      CR = 1'b0;
      chk("rst_ringing", 32'(ringing), 32'd0);
      chk("rst_snoozing", 32'(snoozing), 32'd0);
      chk("rst_actch", 32'(act_ch), 32'd0);
      chk("rst_bell", 32'(bell), 32'd0);

      // hourly chime, table driven
      for (int i = 0; i < 22; i++) begin
         Hour   = vecs[i].hour;
         Min    = vecs[i].min;
         Sec    = vecs[i].sec;
         ToneHi = vecs[i].hi;
         ToneLo = vecs[i].lo;
         #1;
         chk($sformatf("chime_%0d", i), 32'(bell), 32'(vecs[i].exp_bell));
         chk($sformatf("nochime_%0d", i), 32'(bell_nc), 32'd0);
      end

      // ch1 at 07:30: ring, beat, auto-stop after 4 ticks
      AlmHr[15:8]  = 8'h07;
      AlmMin[15:8] = 8'h30;
      AlmEn        = 4'b0010;
      ToneHi = 1'b1;
      ToneLo = 1'b0;
      set_tod(hms(7, 29, 58));
      cycles(1);
      advance();
      chk("pre_ring", 32'(ringing), 32'd0);
      set_tod(tod + 1);
      Tick1Hz = 1'b1;
      cycles(1);
      Tick1Hz = 1'b0;
      chk("ring_latency", 32'(ringing), 32'd1);
      chk("ring_actch1", 32'(act_ch), 32'd1);
      chk("ring_bell_on", 32'(bell), 32'd1);
      ToneHi = 1'b0;
      #1;
      chk("ring_bell_tone", 32'(bell), 32'd0);
      ToneHi = 1'b1;
      cycles(1);
      advance();
      chk("ring_beat_off", 32'(bell), 32'd0);
      chk("ring_t1", 32'(ringing), 32'd1);
      advance();
      chk("ring_beat_on2", 32'(bell), 32'd1);
      advance();
      chk("ring_t3", 32'(ringing), 32'd1);
      advance();
      chk("ring_autostop", 32'(ringing), 32'd0);
      chk("ring_autostop_bell", 32'(bell), 32'd0);

      // ch0 and ch2 at 06:00: lowest wins, disabling owner drops to IDLE
      AlmHr        = '0;
      AlmMin       = '0;
      AlmHr[7:0]   = 8'h06;
      AlmHr[23:16] = 8'h06;
      AlmEn        = 4'b0101;
      set_tod(hms(5, 59, 59));
      cycles(1);
      advance();
      chk("dual_ring", 32'(ringing), 32'd1);
      chk("dual_actch0", 32'(act_ch), 32'd0);
      AlmEn = 4'b0100;
      cycles(1);
      chk("disable_idle", 32'(ringing), 32'd0);
      advance();
      chk("ch2_not_rung", 32'(ringing), 32'd0);

      // snooze: 60 ticks back to RING, second snooze ignored, stop
      AlmHr        = '0;
      AlmMin       = '0;
      AlmHr[15:8]  = 8'h07;
      AlmMin[15:8] = 8'h30;
      AlmEn        = 4'b0010;
      ring_ch1();
      chk("snz_pre_ring", 32'(ringing), 32'd1);
      SnoozeKey = 1'b1;
      cycles(1);
      chk("snz_key_lat1", 32'(snoozing), 32'd0);
      cycles(1);
      SnoozeKey = 1'b0;
      chk("snz_key_lat2", 32'(snoozing), 32'd1);
      cycles(2);
      chk("snz_ringing0", 32'(ringing), 32'd0);
      chk("snz_bell0", 32'(bell), 32'd0);
      for (int i = 0; i < 59; i++) advance();
      chk("snz_59", 32'(snoozing), 32'd1);
      advance();
      chk("snz_60_ring", 32'(ringing), 32'd1);
      chk("snz_60_actch", 32'(act_ch), 32'd1);
      chk("snz_60_bell", 32'(bell), 32'd1);
      key_pulse(1'b1, 1'b0);
      chk("snz_max_ring", 32'(ringing), 32'd1);
      chk("snz_max_snz", 32'(snoozing), 32'd0);
      key_pulse(1'b0, 1'b1);
      chk("stop_idle", 32'(ringing), 32'd0);

      // both keys together: stop wins
      ring_ch1();
      chk("both_pre", 32'(ringing), 32'd1);
      key_pulse(1'b1, 1'b1);
      chk("both_ring", 32'(ringing), 32'd0);
      chk("both_snz", 32'(snoozing), 32'd0);

      // reset mid-snooze, then allowance restored
      ring_ch1();
      key_pulse(1'b1, 1'b0);
      chk("cr_pre_snz", 32'(snoozing), 32'd1);
      CR = 1'b1;
      cycles(1);
      CR = 1'b0;
      chk("cr_ringing", 32'(ringing), 32'd0);
      chk("cr_snoozing", 32'(snoozing), 32'd0);
      chk("cr_actch", 32'(act_ch), 32'd0);
      chk("cr_bell", 32'(bell), 32'd0);
      ring_ch1();
      chk("cr_rering", 32'(ringing), 32'd1);
      chk("cr_rering_ch", 32'(act_ch), 32'd1);
      key_pulse(1'b1, 1'b0);
      chk("cr_snz_restored", 32'(snoozing), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
